// File: rtl/user_proj_gpio.sv
// Wishbone-mapped GPIO block: output/enable registers, synchronised inputs,
// per-channel edge interrupts folded onto IRQ_LINES level outputs.
module user_proj_gpio #(
  parameter int          NUM_IO    = 16,
  parameter int          IRQ_LINES = 3,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic [NUM_IO-1:0]    io_in,
  output logic [NUM_IO-1:0]    io_out,
  output logic [NUM_IO-1:0]    io_oeb,
  output logic [IRQ_LINES-1:0] irq
);

  localparam logic [5:0]  OFF_DOUT = 6'h00;
  localparam logic [5:0]  OFF_OE   = 6'h01;
  localparam logic [5:0]  OFF_DIN  = 6'h02;
  localparam logic [5:0]  OFF_EN   = 6'h03;
  localparam logic [5:0]  OFF_RISE = 6'h04;
  localparam logic [5:0]  OFF_STAT = 6'h05;
  localparam logic [5:0]  OFF_ID   = 6'h06;
  localparam logic [31:0] ID_VAL   = 32'h4750_0000 | 32'(NUM_IO);

  // Channels i with i mod IRQ_LINES == k feed irq[k].
  function automatic logic [NUM_IO-1:0] lane_mask(input int k);
    logic [NUM_IO-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if ((i % IRQ_LINES) == k) m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  logic                 r_ack;
  logic [31:0]          r_dat;
  logic [NUM_IO-1:0]    r_dout;
  logic [NUM_IO-1:0]    r_oe;
  logic [NUM_IO-1:0]    r_en;
  logic [NUM_IO-1:0]    r_rise;
  logic [NUM_IO-1:0]    r_stat;
  logic [NUM_IO-1:0]    r_sync1;
  logic [NUM_IO-1:0]    r_din;
  logic [NUM_IO-1:0]    r_prev;
  logic [IRQ_LINES-1:0] r_irq;

  logic                 w_hit;
  logic                 w_wr;
  logic [5:0]           w_off;
  logic [31:0]          w_bmask;
  logic [NUM_IO-1:0]    w_bm;
  logic [NUM_IO-1:0]    w_wd;
  logic [NUM_IO-1:0]    w_event;
  logic [NUM_IO-1:0]    w_w1c;
  logic [NUM_IO-1:0]    w_stat_next;
  logic [NUM_IO-1:0]    w_pend;
  logic [IRQ_LINES-1:0] w_irq_next;
  logic [31:0]          w_rdata;
  logic                 w_unused_ok;

  // Assert asynchronously, release on the second clock edge so every flop
  // below leaves reset on the same edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_hit = wbs_cyc_i & wbs_stb_i & ~r_ack &
                 (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_wr  = w_hit & wbs_we_i;
  assign w_off = wbs_adr_i[7:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_bmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  assign w_bm = w_bmask[NUM_IO-1:0];
  assign w_wd = wbs_dat_i[NUM_IO-1:0];

  function automatic logic [NUM_IO-1:0] merge(input logic [NUM_IO-1:0] old_v,
                                              input logic [NUM_IO-1:0] new_v,
                                              input logic [NUM_IO-1:0] bm);
    return (old_v & ~bm) | (new_v & bm);
  endfunction

  assign w_event = r_en & ((r_rise & r_din & ~r_prev) | (~r_rise & ~r_din & r_prev));
  assign w_w1c   = (w_wr && (w_off == OFF_STAT)) ? (w_wd & w_bm) : '0;
  // A fresh event re-sets the bit even if software clears it in the same cycle.
  assign w_stat_next = (r_stat & ~w_w1c) | w_event;
  assign w_pend      = r_stat & r_en;

  generate
    for (gi = 0; gi < IRQ_LINES; gi++) begin : g_irq
      assign w_irq_next[gi] = |(w_pend & lane_mask(gi));
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_DOUT: w_rdata[NUM_IO-1:0] = r_dout;
      OFF_OE:   w_rdata[NUM_IO-1:0] = r_oe;
      OFF_DIN:  w_rdata[NUM_IO-1:0] = r_din;
      OFF_EN:   w_rdata[NUM_IO-1:0] = r_en;
      OFF_RISE: w_rdata[NUM_IO-1:0] = r_rise;
      OFF_STAT: w_rdata[NUM_IO-1:0] = r_stat;
      OFF_ID:   w_rdata             = ID_VAL;
      default:  w_rdata             = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_dout  <= '0;
      r_oe    <= '0;
      r_en    <= '0;
      r_rise  <= '0;
      r_stat  <= '0;
      r_sync1 <= '0;
      r_din   <= '0;
      r_prev  <= '0;
      r_irq   <= '0;
    end else begin
      r_ack   <= w_hit;
      r_dat   <= (w_hit && !wbs_we_i) ? w_rdata : 32'h0;
      r_sync1 <= io_in;
      r_din   <= r_sync1;
      r_prev  <= r_din;
      r_stat  <= w_stat_next;
      r_irq   <= w_irq_next;
      if (w_wr) begin
        case (w_off)
          OFF_DOUT: r_dout <= merge(r_dout, w_wd, w_bm);
          OFF_OE:   r_oe   <= merge(r_oe,   w_wd, w_bm);
          OFF_EN:   r_en   <= merge(r_en,   w_wd, w_bm);
          OFF_RISE: r_rise <= merge(r_rise, w_wd, w_bm);
          default:  ;
        endcase
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign io_out    = r_dout;
  assign io_oeb    = ~r_oe;
  assign irq       = r_irq;

  // Address byte offset and data/lane bits above NUM_IO have no effect.
  assign w_unused_ok = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, w_bmask};

endmodule

// File: tb/tb_user_proj_gpio.sv
// Directed bench for user_proj_gpio: register-map vector table plus
// hand-written sequences for synchroniser, interrupts, window and reset.
module tb_user_proj_gpio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] io_in, io_out, io_oeb;
  logic [2:0]  irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  user_proj_gpio dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic [15:0] exp_out;
    logic [15:0] exp_oeb;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic wb(input logic w, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, input string tag, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(posedge clk); #1;
    chk({tag, " ack_high"}, {31'h0, ack}, 32'h1);
    rd = rdat;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ack_one_cycle"}, {31'h0, ack}, 32'h0);
    if (!w) chk({tag, " dat_idle"}, rdat, 32'h0);
    @(negedge clk);
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    wb(1'b0, a, 4'hF, 32'h0, tag, v);
    chk({tag, " rdata"}, v, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] v;
    wb(1'b1, a, 4'hF, d, tag, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int          lat;

    vecs[0]  = '{1'b1, 32'h3000_0004, 4'hF, 32'h0000_00FF, 32'h0, 16'h0000, 16'hFF00};
    vecs[1]  = '{1'b1, 32'h3000_0000, 4'h1, 32'h0000_1234, 32'h0, 16'h0034, 16'hFF00};
    vecs[2]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,         32'h0000_0034, 16'h0034, 16'hFF00};
    vecs[3]  = '{1'b0, 32'h3000_0004, 4'hF, 32'h0,         32'h0000_00FF, 16'h0034, 16'hFF00};
    vecs[4]  = '{1'b1, 32'h3000_0000, 4'h2, 32'h0000_AB00, 32'h0, 16'hAB34, 16'hFF00};
    vecs[5]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,         32'h0000_AB34, 16'hAB34, 16'hFF00};
    vecs[6]  = '{1'b1, 32'h3000_0000, 4'hF, 32'hFFFF_5678, 32'h0, 16'h5678, 16'hFF00};
    vecs[7]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,         32'h0000_5678, 16'h5678, 16'hFF00};
    vecs[8]  = '{1'b1, 32'h3000_0004, 4'h2, 32'h0000_0F00, 32'h0, 16'h5678, 16'hF000};
    vecs[9]  = '{1'b0, 32'h3000_0004, 4'hF, 32'h0,         32'h0000_0FFF, 16'h5678, 16'hF000};
    vecs[10] = '{1'b0, 32'h3000_0018, 4'hF, 32'h0,         32'h4750_0010, 16'h5678, 16'hF000};
    vecs[11] = '{1'b1, 32'h3000_0018, 4'hF, 32'hFFFF_FFFF, 32'h0, 16'h5678, 16'hF000};
    vecs[12] = '{1'b0, 32'h3000_0018, 4'hF, 32'h0,         32'h4750_0010, 16'h5678, 16'hF000};
    vecs[13] = '{1'b1, 32'h3000_003C, 4'hF, 32'hFFFF_FFFF, 32'h0, 16'h5678, 16'hF000};
    vecs[14] = '{1'b0, 32'h3000_003C, 4'hF, 32'h0,         32'h0,         16'h5678, 16'hF000};
    vecs[15] = '{1'b1, 32'h3000_0008, 4'hF, 32'h0000_FFFF, 32'h0, 16'h5678, 16'hF000};
    vecs[16] = '{1'b0, 32'h3000_0008, 4'hF, 32'h0,         32'h0,         16'h5678, 16'hF000};
    vecs[17] = '{1'b0, 32'h3000_000C, 4'hF, 32'h0,         32'h0,         16'h5678, 16'hF000};
    vecs[18] = '{1'b0, 32'h3000_0020, 4'hF, 32'h0,         32'h0,         16'h5678, 16'hF000};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = 32'h0; wdat = 32'h0; io_in = 16'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", {31'h0, ack}, 32'h0);
    chk("reset dat_o", rdat, 32'h0);
    chk("reset io_out", {16'h0, io_out}, 32'h0);
    chk("reset io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
    chk("reset irq", {29'h0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      wb(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, $sformatf("vec%0d", i), v);
      if (!vecs[i].we) chk($sformatf("vec%0d rdata", i), v, vecs[i].exp_rd);
      chk($sformatf("vec%0d io_out", i), {16'h0, io_out}, {16'h0, vecs[i].exp_out});
      chk($sformatf("vec%0d io_oeb", i), {16'h0, io_oeb}, {16'h0, vecs[i].exp_oeb});
      $display("vec%0d we=%0b adr=%h sel=%h wdat=%h rd=%h io_out=%h io_oeb=%h",
               i, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, v, io_out, io_oeb);
    end

    // Input synchroniser
    io_in = 16'h0005;
    repeat (3) @(negedge clk);
    rd_chk(32'h3000_0008, 32'h0000_0005, "din");
    io_in = 16'h0000;
    repeat (3) @(negedge clk);

    // Rising interrupt on channel 1
    wr(32'h3000_000C, 32'h0000_0002, "en1");
    wr(32'h3000_0010, 32'h0000_0002, "rise1");
    io_in[1] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (irq[1] && lat == 0) lat = c;
    end
    chk("irq1 latency<=4", {31'h0, (lat >= 1 && lat <= 4)}, 32'h1);
    chk("irq1 value", {29'h0, irq}, 32'h2);
    @(negedge clk);
    rd_chk(32'h3000_0014, 32'h0000_0002, "stat1");
    wr(32'h3000_0014, 32'h0000_0002, "w1c1");
    chk("irq1 cleared", {29'h0, irq}, 32'h0);
    rd_chk(32'h3000_0014, 32'h0, "stat1 cleared");
    $display("irq rise ch1: latency=%0d cycles", lat);

    // Pulse on a disabled channel leaves status untouched
    io_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    io_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    rd_chk(32'h3000_0014, 32'h0, "stat disabled ch0");
    chk("irq disabled ch0", {29'h0, irq}, 32'h0);

    // Masking via IRQ_EN keeps status
    io_in[1] = 1'b0;
    repeat (4) @(negedge clk);
    io_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    chk("irq1 again", {29'h0, irq}, 32'h2);
    wr(32'h3000_000C, 32'h0, "en off");
    chk("irq masked", {29'h0, irq}, 32'h0);
    rd_chk(32'h3000_0014, 32'h0000_0002, "stat kept when masked");
    wr(32'h3000_0014, 32'h0000_0002, "w1c masked");

    // Falling event on ch4 coincident with W1C: set wins
    wr(32'h3000_000C, 32'h0000_0010, "en4");
    wr(32'h3000_0010, 32'h0000_0000, "rise0");
    io_in[4] = 1'b1;
    repeat (4) @(negedge clk);
    io_in[4] = 1'b0;
    repeat (4) @(negedge clk);
    rd_chk(32'h3000_0014, 32'h0000_0010, "stat4 fall");
    io_in[4] = 1'b1;
    repeat (4) @(negedge clk);
    io_in[4] = 1'b0;
    repeat (2) @(negedge clk);
    wr(32'h3000_0014, 32'h0000_0010, "w1c4 with event");
    rd_chk(32'h3000_0014, 32'h0000_0010, "stat4 set wins");
    chk("irq ch4 on line1", {29'h0, irq}, 32'h2);
    wr(32'h3000_0014, 32'h0000_0010, "w1c4 plain");
    rd_chk(32'h3000_0014, 32'h0, "stat4 cleared");

    // Out-of-window access is never acked
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100; sel = 4'hF;
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack) lat++;
    end
    chk("out-of-window acks", lat, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    $display("window 0x30000100: acks over 10 cycles=%0d", lat);
    @(negedge clk);

    // Reset in the cycle after a hit
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000; sel = 4'hF; wdat = 32'h0000_FFFF;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort ack", {31'h0, ack}, 32'h0);
    chk("abort io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
    chk("abort io_out", {16'h0, io_out}, 32'h0);
    chk("abort irq", {29'h0, irq}, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk(32'h3000_0000, 32'h0, "post-reset dout");
    rd_chk(32'h3000_0004, 32'h0, "post-reset oe");
    chk("post-reset io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
    $display("reset abort: io_out=%h io_oeb=%h", io_out, io_oeb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
